// File: rtl/spi_master_ch_pkg.sv
// rtl/spi_master_ch_pkg.sv - shared constants, FSM encodings and helpers for spi_master_ch
package spi_master_ch_pkg;

    localparam int W_CPU       = 8;
    localparam int CLK_DIV_DEF = 2;
    localparam int N_SS_DEF    = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Slave-select index width; a single slave still gets a 1-bit port.
    function automatic int ss_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_ch_clk_gen.sv
// rtl/spi_master_ch_clk_gen.sv - SCLK divider with one-cycle leading/trailing edge strobes
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic idle_lvl,
    output logic spi_clk,
    output logic lead_edge,
    output logic trail_edge
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;

    // The strobes fire in the cycle whose clock edge moves spi_clk, so the
    // master can sample/shift in lockstep with the registered SCLK change.
    assign tick       = en && (cnt == CW'(CLK_DIV - 1));
    assign lead_edge  = tick && (spi_clk == idle_lvl);
    assign trail_edge = tick && (spi_clk != idle_lvl);

    // Divider: SCLK parks at the idle level whenever the transfer phase is not active.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            spi_clk <= idle_lvl;
        end else if (!en) begin
            cnt     <= '0;
            spi_clk <= idle_lvl;
        end else if (tick) begin
            cnt     <= '0;
            spi_clk <= ~spi_clk;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ch.sv
// rtl/spi_master_ch.sv - full-duplex SPI master; SPI_MODE_SEL_EN adds runtime cpol/cpha
module spi_master_ch
    import spi_master_ch_pkg::*;
#(
    parameter int W_Data  = W_CPU,
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int N_SS    = N_SS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [W_Data-1:0]           tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [ss_width(N_SS)-1:0]   ss_sel,
`ifdef SPI_MODE_SEL_EN
    input  logic                        cpol,
    input  logic                        cpha,
`endif
    output logic [W_Data-1:0]           rx_data,
    output logic                        rx_valid,
    output logic                        busy,
    output logic                        spi_clk,
    output logic [N_SS-1:0]             ss_n,
    output logic                        mosi,
    input  logic                        miso
);

    localparam int SS_W = ss_width(N_SS);
    localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BCW  = $clog2(W_Data) + 1;

    logic [1:0]        state;
    logic [CW-1:0]     ph_cnt;
    logic [BCW-1:0]    bit_cnt;
    logic [W_Data-1:0] tx_sh;
    logic [W_Data-1:0] rx_sh;
    logic              cpol_q;
    logic              cpha_q;
    logic              cpol_in;
    logic              cpha_in;
    logic              idle_lvl;
    logic              lead_edge;
    logic              trail_edge;
    logic              last_bit;
    logic [N_SS-1:0]   ss_dec;

`ifdef SPI_MODE_SEL_EN
    assign cpol_in = cpol;
    assign cpha_in = cpha;
`else
    assign cpol_in = 1'b0;
    assign cpha_in = 1'b0;
`endif

    assign busy     = (state != ST_IDLE);
    assign last_bit = (bit_cnt == BCW'(W_Data - 1));
    // Idle level tracks the live cpol input only while no transfer owns the bus.
    assign idle_lvl = (state == ST_IDLE || !rst) ? cpol_in : cpol_q;

    // One-hot-low select decode; an out-of-range index asserts no line.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < N_SS; i++) begin
            if (ss_sel == SS_W'(i)) begin
                ss_dec[i] = 1'b0;
            end
        end
    end

    spi_clk_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (state == ST_XFER),
        .idle_lvl   (idle_lvl),
        .spi_clk    (spi_clk),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    // Transfer sequencer: accept, select setup, shift/sample, select hold, complete.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            mosi     <= 1'b0;
            ss_n     <= '1;
            ph_cnt   <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        tx_ready <= 1'b0;
                        tx_sh    <= tx_data;
                        rx_sh    <= '0;
                        bit_cnt  <= '0;
                        ph_cnt   <= '0;
                        cpol_q   <= cpol_in;
                        cpha_q   <= cpha_in;
                        ss_n     <= ss_dec;
                        state    <= ST_SETUP;
                        // Mode with CPHA=0 needs the MSB valid before the first edge.
                        if (!cpha_in) begin
                            mosi <= tx_data[W_Data-1];
                        end
                    end
                end
                ST_SETUP: begin
                    if (ph_cnt == CW'(CLK_DIV - 1)) begin
                        ph_cnt <= '0;
                        state  <= ST_XFER;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (lead_edge) begin
                        if (cpha_q) begin
                            mosi  <= tx_sh[W_Data-1];
                            tx_sh <= tx_sh << 1;
                        end else begin
                            rx_sh <= {rx_sh[W_Data-2:0], miso};
                        end
                    end
                    if (trail_edge) begin
                        if (cpha_q) begin
                            rx_sh <= {rx_sh[W_Data-2:0], miso};
                        end else if (!last_bit) begin
                            mosi  <= tx_sh[W_Data-2];
                            tx_sh <= tx_sh << 1;
                        end
                        if (last_bit) begin
                            state <= ST_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (ph_cnt == CW'(CLK_DIV - 1)) begin
                        ph_cnt   <= '0;
                        state    <= ST_IDLE;
                        ss_n     <= '1;
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        tx_ready <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ch.sv
// tb/tb_spi_master_ch.sv - directed self-checking bench for spi_master_ch
module tb_spi_master_ch;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [7:0]  a_tx_data  = '0;
    logic        a_tx_valid = 1'b0;
    logic        a_tx_ready;
    logic        a_ss_sel   = 1'b0;
    logic [7:0]  a_rx_data;
    logic        a_rx_valid;
    logic        a_busy;
    logic        a_spi_clk;
    logic [1:0]  a_ss_n;
    logic        a_mosi;
    logic        a_miso;
    logic        a_loop     = 1'b1;
    logic        slv_miso   = 1'b0;
    logic [7:0]  slv_tx     = '0;
    logic [7:0]  slv_rx     = '0;

    logic [31:0] b_tx_data  = '0;
    logic        b_tx_valid = 1'b0;
    logic        b_tx_ready;
    logic [1:0]  b_ss_sel   = '0;
    logic [31:0] b_rx_data;
    logic        b_rx_valid;
    logic        b_busy;
    logic        b_spi_clk;
    logic [2:0]  b_ss_n;
    logic        b_mosi;

`ifdef SPI_MODE_SEL_EN
    logic a_cpol = 1'b0;
    logic a_cpha = 1'b0;
    logic b_cpol = 1'b0;
    logic b_cpha = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    assign a_miso = a_loop ? a_mosi : slv_miso;

    always #5 clk = ~clk;

    spi_master_ch #(.W_Data(8), .CLK_DIV(2), .N_SS(2)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (a_tx_data),
        .tx_valid (a_tx_valid),
        .tx_ready (a_tx_ready),
        .ss_sel   (a_ss_sel),
`ifdef SPI_MODE_SEL_EN
        .cpol     (a_cpol),
        .cpha     (a_cpha),
`endif
        .rx_data  (a_rx_data),
        .rx_valid (a_rx_valid),
        .busy     (a_busy),
        .spi_clk  (a_spi_clk),
        .ss_n     (a_ss_n),
        .mosi     (a_mosi),
        .miso     (a_miso)
    );

    spi_master_ch #(.W_Data(32), .CLK_DIV(1), .N_SS(3)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (b_tx_data),
        .tx_valid (b_tx_valid),
        .tx_ready (b_tx_ready),
        .ss_sel   (b_ss_sel),
`ifdef SPI_MODE_SEL_EN
        .cpol     (b_cpol),
        .cpha     (b_cpha),
`endif
        .rx_data  (b_rx_data),
        .rx_valid (b_rx_valid),
        .busy     (b_busy),
        .spi_clk  (b_spi_clk),
        .ss_n     (b_ss_n),
        .mosi     (b_mosi),
        .miso     (b_mosi)
    );

    // Slave for the non-loopback case: shifts out on falling SCLK, captures on rising.
    always @(negedge a_spi_clk) begin
        if (!a_loop && !a_ss_n[1]) begin
            slv_miso = slv_tx[7];
            slv_tx   = slv_tx << 1;
        end
    end

    always @(posedge a_spi_clk) begin
        if (!a_loop && !a_ss_n[1]) begin
            slv_rx = {slv_rx[6:0], a_mosi};
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic xfer_a(input logic [7:0] d, input logic ss, output int cyc,
                          output int rises, output logic [1:0] ss_seen, output logic [7:0] rx);
        logic prev;
        @(negedge clk);
        check("a_ready_pre", a_tx_ready, 1'b1);
        a_tx_data  = d;
        a_ss_sel   = ss;
        a_tx_valid = 1'b1;
        @(posedge clk);
        #1;
        a_tx_valid = 1'b0;
        cyc     = 0;
        rises   = 0;
        ss_seen = 2'b11;
        prev    = a_spi_clk;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (a_spi_clk && !prev) rises++;
            prev = a_spi_clk;
            if (a_ss_n != 2'b11) ss_seen = a_ss_n;
            if (a_rx_valid) break;
        end
        rx = a_rx_data;
    endtask

    task automatic xfer_b(input logic [31:0] d, input logic [1:0] ss, output int cyc,
                          output logic [2:0] ss_seen, output logic [31:0] rx);
        @(negedge clk);
        b_tx_data  = d;
        b_ss_sel   = ss;
        b_tx_valid = 1'b1;
        @(posedge clk);
        #1;
        b_tx_valid = 1'b0;
        cyc     = 0;
        ss_seen = 3'b111;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (b_ss_n != 3'b111) ss_seen = b_ss_n;
            if (b_rx_valid) break;
        end
        rx = b_rx_data;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          rises;
        int          n;
        int          pulses;
        int          sel_cnt;
        logic [1:0]  ss_seen;
        logic [2:0]  ss3;
        logic [7:0]  rx;
        logic [31:0] rx32;

        // Reset values
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_ready", a_tx_ready, 1'b0);
        check("rst_busy",     a_busy,     1'b0);
        check("rst_rx_valid", a_rx_valid, 1'b0);
        check("rst_rx_data",  a_rx_data,  8'h00);
        check("rst_mosi",     a_mosi,     1'b0);
        check("rst_ss_n",     a_ss_n,     2'b11);
        check("rst_spi_clk",  a_spi_clk,  1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_tx_ready", a_tx_ready, 1'b1);

        // Mode 0 loopback 0xA5 on slave 0: rx_valid at cycle 2*2*(8+1)+1 = 37
        xfer_a(8'hA5, 1'b0, cyc, rises, ss_seen, rx);
        check("m0_rx_cycle", cyc + 1, 37);
        check("m0_rises",    rises,   8);
        check("m0_ss_n",     ss_seen, 2'b10);
        check("m0_rx_data",  rx,      8'hA5);
        check("m0_done_ss",  a_ss_n,  2'b11);
        check("m0_done_rdy", a_tx_ready, 1'b1);
        @(posedge clk);
        #1;
        check("m0_pulse_1",  a_rx_valid, 1'b0);
        check("m0_sclk_idle", a_spi_clk, 1'b0);
        check("m0_rx_hold",  a_rx_data,  8'hA5);

        // Mode 0 loopback 0x3C on slave 1
        xfer_a(8'h3C, 1'b1, cyc, rises, ss_seen, rx);
        check("m0b_ss_n",    ss_seen, 2'b01);
        check("m0b_rx_data", rx,      8'h3C);

        // Back-to-back: tx_valid held, second word accepted in the rx_valid cycle
        @(negedge clk);
        a_tx_data  = 8'h01;
        a_ss_sel   = 1'b0;
        a_tx_valid = 1'b1;
        @(posedge clk);
        #1;
        a_tx_data = 8'h02;
        n = 0;
        while (n < 200 && !a_rx_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_rx1",     a_rx_data, 8'h01);
        check("b2b_gap_hi",  a_ss_n,    2'b11);
        @(posedge clk);
        #1;
        a_tx_valid = 1'b0;
        check("b2b_relow",   a_ss_n,    2'b10);
        check("b2b_busy",    a_busy,    1'b1);
        n = 0;
        while (n < 200 && !a_rx_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_rx2_seen", a_rx_valid, 1'b1);
        check("b2b_rx2",      a_rx_data,  8'h02);

        // tx_valid pulsed mid-transfer is ignored
        @(negedge clk);
        a_tx_data  = 8'h55;
        a_ss_sel   = 1'b0;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("ign_busy", a_busy, 1'b1);
        a_tx_data  = 8'hFF;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        pulses  = 0;
        sel_cnt = 0;
        rx      = '0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (a_rx_valid) begin
                pulses++;
                rx = a_rx_data;
            end
            if (pulses > 0 && a_ss_n != 2'b11) sel_cnt++;
        end
        check("ign_pulses",  pulses,  1);
        check("ign_rx",      rx,      8'h55);
        check("ign_no_next", sel_cnt, 0);

        // Reset asserted for 3 cycles mid-XFER aborts the word
        @(negedge clk);
        a_tx_data  = 8'hA5;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_in_xfer", a_ss_n, 2'b10);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("mid_rst_ss_n", a_ss_n,     2'b11);
            check("mid_rst_sclk", a_spi_clk,  1'b0);
            check("mid_rst_rxv",  a_rx_valid, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_ready", a_tx_ready, 1'b1);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (a_rx_valid) pulses++;
        end
        check("mid_no_rxv", pulses, 0);

        // Wide word, CLK_DIV=1, out-of-range select: rx_valid at cycle 2*1*33+1 = 67
        xfer_b(32'hDEADBEEF, 2'd3, cyc, ss3, rx32);
        check("w32_rx_cycle", cyc + 1, 67);
        check("w32_no_ss",    ss3,     3'b111);
        check("w32_rx_data",  rx32,    32'hDEADBEEF);
        xfer_b(32'h1234_5678, 2'd2, cyc, ss3, rx32);
        check("w32b_ss_n",    ss3,     3'b011);
        check("w32b_rx_data", rx32,    32'h1234_5678);

`ifdef SPI_MODE_SEL_EN
        // Mode 3 against a slave model returning 0x3C on slave 1
        a_loop = 1'b0;
        a_cpol = 1'b1;
        a_cpha = 1'b1;
        slv_tx = 8'h3C;
        slv_rx = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("m3_idle_hi", a_spi_clk, 1'b1);
        xfer_a(8'hC3, 1'b1, cyc, rises, ss_seen, rx);
        check("m3_rx_cycle", cyc + 1, 37);
        check("m3_rises",    rises,   8);
        check("m3_ss_n",     ss_seen, 2'b01);
        check("m3_slave_rx", slv_rx,  8'hC3);
        check("m3_rx_data",  rx,      8'h3C);
        check("m3_sclk_idle", a_spi_clk, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
